mc_run_scheduler: RTL and testbench

//  Dispatches N Monte Carlo runs across LANES parallel sim_mng lanes, one run per lane at a time.

---
 rtl/mc_pkg.sv | 27 ++
 rtl/mc_pct_div.sv | 85 ++++++++
 rtl/mc_run_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_mc_run_scheduler.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the Monte Carlo run scheduler.
//  - default widths (SEED_W, N_W), percentage scale (PCT_SCALE)
//  - scheduler state enum, small popcount helper
package mc_pkg;

    localparam int unsigned SEED_W    = 23;
    localparam int unsigned N_W       = 8;
    localparam int unsigned PCT_SCALE = 100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_e;

    // Count set bits of a lane vector (lane count is at most 8).
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + 4'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/mc_pct_div.sv
// Sequential restoring divider, one quotient bit per cycle (NUM_W cycles).
// Ports:
//  clk, rst   clock, synchronous active-high reset
//  start      1-cycle pulse: latch num/den and begin dividing
//  num, den   dividend / divisor, sampled on start
//  quot       quotient, valid from ready and held until the next start
//  ready      1-cycle pulse when quot is valid
module mc_pct_div #(
    parameter int unsigned NUM_W = 15,
    parameter int unsigned DEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic [NUM_W-1:0] quot,
    output logic             ready
);

    localparam int unsigned CNT_W = $clog2(NUM_W + 1);

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DEN_W-1:0] rem_q, rem_d;
    logic [NUM_W-1:0] quo_q, quo_d;
    logic [DEN_W-1:0] den_q, den_d;
    logic             ready_q, ready_d;

    logic [DEN_W:0]   shifted_c;
    logic [DEN_W:0]   diff_c;
    logic             ge_c;

    // Dividend bits shift out of quo_q into the remainder; quotient bits shift in.
    always_comb begin
        active_d  = active_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        den_d     = den_q;
        ready_d   = 1'b0;
        shifted_c = {rem_q, quo_q[NUM_W-1]};
        diff_c    = shifted_c - {1'b0, den_q};
        ge_c      = (shifted_c >= {1'b0, den_q});

        if (start) begin
            active_d = 1'b1;
            cnt_d    = CNT_W'(NUM_W);
            rem_d    = '0;
            quo_d    = num;
            den_d    = den;
        end else if (active_q) begin
            // Remainder stays below den, so the low DEN_W bits hold it exactly.
            rem_d = ge_c ? diff_c[DEN_W-1:0] : shifted_c[DEN_W-1:0];
            quo_d = {quo_q[NUM_W-2:0], ge_c};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                active_d = 1'b0;
                ready_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            den_q    <= '0;
            ready_q  <= 1'b0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            den_q    <= den_d;
            ready_q  <= ready_d;
        end
    end

    assign quot  = quo_q;
    assign ready = ready_q;

endmodule

// File: rtl/mc_run_scheduler.sv
// Dispatches N Monte Carlo runs over LANES sim lanes, one run per lane at a time,
// gives each run seed_base+k, tallies results and computes P = success*100/N.
// Ports:
//  clk, rst              clock, synchronous active-high reset
//  start, n_runs, seed_base   batch request (n_runs/seed_base sampled on start)
//  lane_start, lane_seed      per-lane start pulse and seed
//  lane_done, lane_y          per-lane completion pulse and result
//  busy, done                 batch in progress / 1-cycle result pulse
//  num_success, num_runs      running tallies
//  p_pct                      success percentage, held until next start
module mc_run_scheduler #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned SEED_W = mc_pkg::SEED_W,
    parameter int unsigned N_W    = mc_pkg::N_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N_W-1:0]           n_runs,
    input  logic [SEED_W-1:0]        seed_base,
    output logic [LANES-1:0]         lane_start,
    output logic [LANES*SEED_W-1:0]  lane_seed,
    input  logic [LANES-1:0]         lane_done,
    input  logic [LANES-1:0]         lane_y,
    output logic                     busy,
    output logic                     done,
    output logic [N_W-1:0]           num_success,
    output logic [N_W-1:0]           num_runs,
    output logic [7:0]               p_pct
);

    import mc_pkg::*;

    localparam int unsigned NUM_W = N_W + 7;

    state_e                    state_q, state_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [LANES-1:0]          lane_start_q, lane_start_d;
    logic [LANES-1:0]          lane_busy_q, lane_busy_d;
    logic [LANES*SEED_W-1:0]   lane_seed_q, lane_seed_d;
    logic [N_W-1:0]            n_q, n_d;
    logic [N_W-1:0]            issued_q, issued_d;
    logic [SEED_W-1:0]         seed_next_q, seed_next_d;
    logic [N_W-1:0]            num_runs_q, num_runs_d;
    logic [N_W-1:0]            num_success_q, num_success_d;
    logic [7:0]                p_pct_q, p_pct_d;
    logic                      div_start_q, div_start_d;

    logic [LANES-1:0]          fin_c;
    logic [LANES-1:0]          succ_c;
    logic [LANES-1:0]          free_c;
    logic                      dispatch_en_c;
    logic [SEED_W-1:0]         dispatch_seed_c;
    logic [N_W-1:0]            issue_base_c;
    logic                      found_c;

    logic [NUM_W-1:0]          div_num;
    logic [NUM_W-1:0]          div_quot;
    logic                      div_ready;

    assign div_num = NUM_W'(num_success_q) * NUM_W'(PCT_SCALE);

    mc_pct_div #(
        .NUM_W (NUM_W),
        .DEN_W (N_W)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start_q),
        .num   (div_num),
        .den   (n_q),
        .quot  (div_quot),
        .ready (div_ready)
    );

    // Next-state, lane bookkeeping and dispatch.
    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        lane_start_d  = '0;
        lane_seed_d   = lane_seed_q;
        n_d           = n_q;
        issued_d      = issued_q;
        seed_next_d   = seed_next_q;
        num_runs_d    = num_runs_q;
        num_success_d = num_success_q;
        p_pct_d       = p_pct_q;
        div_start_d   = 1'b0;

        // Only completions on lanes we started count; a freed lane is dispatchable at once.
        fin_c           = lane_done & lane_busy_q;
        succ_c          = fin_c & lane_y;
        free_c          = ~lane_busy_q | fin_c;
        lane_busy_d     = lane_busy_q & ~fin_c;
        dispatch_en_c   = 1'b0;
        dispatch_seed_c = seed_next_q;
        issue_base_c    = issued_q;
        found_c         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d        = 1'b1;
                    n_d           = n_runs;
                    num_runs_d    = '0;
                    num_success_d = '0;
                    issued_d      = '0;
                    seed_next_d   = seed_base;
                    if (n_runs == '0) begin
                        state_d = FIN;
                    end else begin
                        // First run goes out on the edge that accepts start.
                        state_d         = RUN;
                        dispatch_en_c   = 1'b1;
                        dispatch_seed_c = seed_base;
                        issue_base_c    = '0;
                    end
                end
            end
            RUN: begin
                num_runs_d    = num_runs_q + N_W'(popcount8(8'(fin_c)));
                num_success_d = num_success_q + N_W'(popcount8(8'(succ_c)));
                dispatch_en_c = (issued_q < n_q);
                if (num_runs_q == n_q) begin
                    state_d     = DIV;
                    div_start_d = 1'b1;
                end
            end
            DIV: begin
                if (div_ready) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                p_pct_d = (n_q == '0) ? 8'd0 : 8'(div_quot);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Lowest-index free lane wins.
        for (int i = 0; i < LANES; i++) begin
            if (dispatch_en_c && free_c[i] && !found_c) begin
                found_c                          = 1'b1;
                lane_start_d[i]                  = 1'b1;
                lane_busy_d[i]                   = 1'b1;
                lane_seed_d[i*SEED_W +: SEED_W]  = dispatch_seed_c;
            end
        end
        if (found_c) begin
            issued_d    = issue_base_c + N_W'(1);
            seed_next_d = dispatch_seed_c + SEED_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            lane_start_q  <= '0;
            lane_busy_q   <= '0;
            lane_seed_q   <= '0;
            n_q           <= '0;
            issued_q      <= '0;
            seed_next_q   <= '0;
            num_runs_q    <= '0;
            num_success_q <= '0;
            p_pct_q       <= '0;
            div_start_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            lane_start_q  <= lane_start_d;
            lane_busy_q   <= lane_busy_d;
            lane_seed_q   <= lane_seed_d;
            n_q           <= n_d;
            issued_q      <= issued_d;
            seed_next_q   <= seed_next_d;
            num_runs_q    <= num_runs_d;
            num_success_q <= num_success_d;
            p_pct_q       <= p_pct_d;
            div_start_q   <= div_start_d;
        end
    end

    assign lane_start  = lane_start_q;
    assign lane_seed   = lane_seed_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign num_success = num_success_q;
    assign num_runs    = num_runs_q;
    assign p_pct       = p_pct_q;

endmodule

// File: tb/tb_mc_run_scheduler.sv
// Directed bench for mc_run_scheduler with a behavioural lane model.
module tb_mc_run_scheduler;

    localparam int unsigned LANES  = 4;
    localparam int unsigned SEED_W = 23;
    localparam int unsigned N_W    = 8;

    logic                    clk;
    logic                    rst;
    logic                    start;
    logic [N_W-1:0]          n_runs;
    logic [SEED_W-1:0]       seed_base;
    logic [LANES-1:0]        lane_start;
    logic [LANES*SEED_W-1:0] lane_seed;
    logic [LANES-1:0]        lane_done;
    logic [LANES-1:0]        lane_y;
    logic                    busy;
    logic                    done;
    logic [N_W-1:0]          num_success;
    logic [N_W-1:0]          num_runs;
    logic [7:0]              p_pct;

    logic [LANES-1:0]        model_done, model_y;
    logic [LANES-1:0]        man_done, man_y;
    bit                      model_en;
    bit                      y_all;

    int n_cmp;
    int n_err;
    int viol;

    logic [SEED_W-1:0] start_log[$];
    logic [SEED_W-1:0] m_seed [LANES];
    int                m_cnt  [LANES];
    bit                m_busy [LANES];

    assign lane_done = model_done | man_done;
    assign lane_y    = model_y | man_y;

    mc_run_scheduler #(
        .LANES  (LANES),
        .SEED_W (SEED_W),
        .N_W    (N_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .n_runs      (n_runs),
        .seed_base   (seed_base),
        .lane_start  (lane_start),
        .lane_seed   (lane_seed),
        .lane_done   (lane_done),
        .lane_y      (lane_y),
        .busy        (busy),
        .done        (done),
        .num_success (num_success),
        .num_runs    (num_runs),
        .p_pct       (p_pct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane model: logs every start, and when enabled answers after a seed-dependent delay
    // with y=1 on even seeds (or always 1 when y_all is set).
    initial begin
        model_done = '0;
        model_y    = '0;
        viol       = 0;
        for (int i = 0; i < LANES; i++) begin
            m_busy[i] = 1'b0;
            m_cnt[i]  = 0;
            m_seed[i] = '0;
        end
        forever begin
            @(negedge clk);
            model_done = '0;
            model_y    = '0;
            for (int i = 0; i < LANES; i++) begin
                if (!model_en) begin
                    m_busy[i] = 1'b0;
                end else if (m_busy[i]) begin
                    m_cnt[i]--;
                    if (m_cnt[i] == 0) begin
                        model_done[i] = 1'b1;
                        model_y[i]    = y_all ? 1'b1 : ~m_seed[i][0];
                        m_busy[i]     = 1'b0;
                    end
                end
                if (lane_start[i]) begin
                    if (m_busy[i]) viol++;
                    m_seed[i] = lane_seed[i*SEED_W +: SEED_W];
                    start_log.push_back(m_seed[i]);
                    m_busy[i] = 1'b1;
                    m_cnt[i]  = 1 + int'(m_seed[i] % 23'd3) + i;
                end
            end
        end
    end

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s_done_timeout: got no done, expected done within 3000 cycles", tag);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; n_runs = '0; seed_base = '0;
        man_done = '0; man_y = '0; model_en = 1'b0; y_all = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, lane_start, num_runs, num_success, p_pct} !== '0 || lane_seed !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b ls=%0h seed=%0h runs=%0d succ=%0d p=%0d, expected all 0",
                     busy, done, lane_start, lane_seed, num_runs, num_success, p_pct);
        end
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1; n_runs = 8'd5; seed_base = 23'h10;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (lane_start !== 4'b0001) begin
            n_err++; $display("FAIL rst_first_start: got %b expected 0001", lane_start);
        end
        @(negedge clk);
        n_cmp++;
        if (lane_start !== 4'b0010) begin
            n_err++; $display("FAIL rst_second_start: got %b expected 0010", lane_start);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, lane_start, num_runs, num_success, p_pct} !== '0 || lane_seed !== '0) begin
            n_err++;
            $display("FAIL midrun_reset: got busy=%0b ls=%0h seed=%0h runs=%0d, expected all 0",
                     busy, lane_start, lane_seed, num_runs);
        end
        man_done = 4'b0011; man_y = 4'b0011;
        @(negedge clk);
        man_done = '0; man_y = '0;
        @(negedge clk);
        n_cmp++;
        if (num_runs !== 8'd0 || num_success !== 8'd0 || busy !== 1'b0 || lane_start !== 4'b0000) begin
            n_err++;
            $display("FAIL late_done_ignored: got runs=%0d succ=%0d busy=%0b ls=%b, expected 0 0 0 0000",
                     num_runs, num_success, busy, lane_start);
        end
    endtask

    task automatic test_simultaneous();
        model_en = 1'b0;
        @(negedge clk);
        start = 1'b1; n_runs = 8'd3; seed_base = 23'd100;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (lane_start !== 4'(1 << k) || lane_seed[k*SEED_W +: SEED_W] !== 23'(100 + k)) begin
                n_err++;
                $display("FAIL sim_dispatch%0d: got ls=%b seed=%0d, expected ls=%b seed=%0d",
                         k, lane_start, lane_seed[k*SEED_W +: SEED_W], 4'(1 << k), 100 + k);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (lane_start !== 4'b0000 || busy !== 1'b1) begin
            n_err++; $display("FAIL sim_no_extra_start: got ls=%b busy=%0b expected 0000 1", lane_start, busy);
        end
        man_done = 4'b1000; man_y = 4'b1000;
        @(negedge clk);
        n_cmp++;
        if (num_runs !== 8'd0 || num_success !== 8'd0) begin
            n_err++; $display("FAIL idle_lane_done: got runs=%0d succ=%0d expected 0 0", num_runs, num_success);
        end
        man_done = 4'b0111; man_y = 4'b0101;
        @(negedge clk);
        man_done = '0; man_y = '0;
        n_cmp++;
        if (num_runs !== 8'd3 || num_success !== 8'd2) begin
            n_err++; $display("FAIL simultaneous_done: got runs=%0d succ=%0d expected 3 2", num_runs, num_success);
        end
        wait_done("sim");
        n_cmp++;
        if (p_pct !== 8'd66 || busy !== 1'b0) begin
            n_err++; $display("FAIL sim_pct: got p=%0d busy=%0b expected 66 0", p_pct, busy);
        end
    endtask

    task automatic test_zero_runs();
        int base;
        @(negedge clk);
        base = start_log.size();
        start = 1'b1; n_runs = 8'd0; seed_base = 23'd7;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++; $display("FAIL zero_cycle1: got busy=%0b done=%0b expected 1 0", busy, done);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || p_pct !== 8'd0 || busy !== 1'b0) begin
            n_err++; $display("FAIL zero_done: got done=%0b p=%0d busy=%0b expected 1 0 0", done, p_pct, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || start_log.size() != base) begin
            n_err++; $display("FAIL zero_after: got done=%0b starts=%0d expected 0 0", done, start_log.size() - base);
        end
    endtask

    task automatic test_mc31();
        int base;
        int bad;
        int cnt;
        model_en = 1'b1; y_all = 1'b0;
        @(negedge clk);
        base = start_log.size();
        start = 1'b1; n_runs = 8'd31; seed_base = 23'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done("mc31");
        n_cmp++;
        if (num_runs !== 8'd31 || num_success !== 8'd15 || p_pct !== 8'd48) begin
            n_err++; $display("FAIL mc31_result: got runs=%0d succ=%0d p=%0d expected 31 15 48",
                              num_runs, num_success, p_pct);
        end
        bad = 0;
        for (int s = 1; s <= 31; s++) begin
            cnt = 0;
            for (int j = base; j < start_log.size(); j++) begin
                if (start_log[j] == 23'(s)) cnt++;
            end
            if (cnt != 1) bad++;
        end
        n_cmp++;
        if (start_log.size() - base != 31 || bad != 0) begin
            n_err++; $display("FAIL mc31_seeds: got starts=%0d bad_seeds=%0d expected 31 0",
                              start_log.size() - base, bad);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL mc31_done_width: got done=%0b busy=%0b expected 0 0", done, busy);
        end
    endtask

    task automatic test_seed_wrap();
        int base;
        logic [SEED_W-1:0] exp_s [4];
        exp_s[0] = 23'h7FFFFE; exp_s[1] = 23'h7FFFFF; exp_s[2] = 23'h000000; exp_s[3] = 23'h000001;
        model_en = 1'b1; y_all = 1'b0;
        @(negedge clk);
        base = start_log.size();
        start = 1'b1; n_runs = 8'd4; seed_base = 23'h7FFFFE;
        @(negedge clk);
        start = 1'b0;
        wait_done("wrap");
        n_cmp++;
        if (start_log.size() - base != 4) begin
            n_err++; $display("FAIL wrap_count: got %0d expected 4", start_log.size() - base);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (start_log[base + k] !== exp_s[k]) begin
                    n_err++; $display("FAIL wrap_seed%0d: got %06h expected %06h", k, start_log[base + k], exp_s[k]);
                end
            end
        end
        n_cmp++;
        if (num_success !== 8'd2 || p_pct !== 8'd50) begin
            n_err++; $display("FAIL wrap_pct: got succ=%0d p=%0d expected 2 50", num_success, p_pct);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int hits;
        model_en = 1'b1; y_all = 1'b1;
        @(negedge clk);
        base = start_log.size();
        start = 1'b1; n_runs = 8'd10; seed_base = 23'd50;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; n_runs = 8'd3; seed_base = 23'd900;
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b");
        n_cmp++;
        if (num_runs !== 8'd10 || num_success !== 8'd10 || p_pct !== 8'd100 || busy !== 1'b0) begin
            n_err++; $display("FAIL b2b_result: got runs=%0d succ=%0d p=%0d busy=%0b expected 10 10 100 0",
                              num_runs, num_success, p_pct, busy);
        end
        hits = 0;
        for (int j = base; j < start_log.size(); j++) begin
            if (start_log[j] == 23'd900) hits++;
        end
        n_cmp++;
        if (start_log.size() - base != 10 || hits != 0) begin
            n_err++; $display("FAIL b2b_ignored_start: got starts=%0d seed900=%0d expected 10 0",
                              start_log.size() - base, hits);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL b2b_after: got done=%0b busy=%0b expected 0 0", done, busy);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        man_done = '0;
        man_y = '0;
        model_en = 1'b0;
        y_all = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        n_runs = '0;
        seed_base = '0;
        test_reset();
        test_simultaneous();
        test_zero_runs();
        test_mc31();
        test_seed_wrap();
        test_back_to_back();
        n_cmp++;
        if (viol != 0) begin
            n_err++; $display("FAIL lane_restart_while_busy: got %0d expected 0", viol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
